// File: rtl/gpio_input_filter.sv
// GPIO input conditioning: 2-FF sync, per-channel stability filter, edge flags and level IRQ on the mem bus.
// Optional GPIO_FILTER_TIMESTAMP_EN adds a free-running cycle counter with event capture at 0x20/0x24.
module gpio_input_filter #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned FILTER_BITS  = 16,
    parameter int unsigned THRESH_RESET = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_rdata,
    output logic                mem_ready,
    output logic                mem_error,
    input  logic [CHANNELS-1:0] pins_raw,
    output logic [CHANNELS-1:0] pins_f,
    output logic                irq
);

    localparam logic [31:0] ID_VALUE    = 32'h4750_4946;
    localparam logic [31:0] ADDR_ID     = 32'h00;
    localparam logic [31:0] ADDR_CHAN   = 32'h04;
    localparam logic [31:0] ADDR_PINS   = 32'h08;
    localparam logic [31:0] ADDR_THRESH = 32'h0C;
    localparam logic [31:0] ADDR_RISE   = 32'h10;
    localparam logic [31:0] ADDR_FALL   = 32'h14;
    localparam logic [31:0] ADDR_FLAGS  = 32'h18;
    localparam logic [31:0] ADDR_MASK   = 32'h1C;
`ifdef GPIO_FILTER_TIMESTAMP_EN
    localparam logic [31:0] ADDR_TS_CAP  = 32'h20;
    localparam logic [31:0] ADDR_TS_LIVE = 32'h24;
`endif

    logic [CHANNELS-1:0]    sync1_q, sync2_q;
    logic [CHANNELS-1:0]    pins_f_q, pins_f_d;
    logic [FILTER_BITS-1:0] cnt_q [CHANNELS];
    logic [FILTER_BITS-1:0] cnt_d [CHANNELS];
    logic [FILTER_BITS-1:0] thresh_q, thresh_d;
    logic [CHANNELS-1:0]    rise_en_q, rise_en_d;
    logic [CHANNELS-1:0]    fall_en_q, fall_en_d;
    logic [CHANNELS-1:0]    flags_q, flags_d;
    logic [CHANNELS-1:0]    mask_q, mask_d;
    logic [CHANNELS-1:0]    set_vec, clr_vec;
    logic                   irq_q;
    logic                   ready_q, error_q, error_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   req, is_rd, is_wr;
    logic                   unused_wdata;

    assign unused_wdata = ^mem_wdata;

`ifdef GPIO_FILTER_TIMESTAMP_EN
    logic [31:0] ts_q, cap_q;
`endif

    // Compare uses >= so a threshold lowered mid-count commits on the next mismatching cycle.
    always_comb begin
        pins_f_d = pins_f_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != pins_f_q[i]) begin
                if (cnt_q[i] >= thresh_q) pins_f_d[i] = sync2_q[i];
                else                      cnt_d[i]    = cnt_q[i] + FILTER_BITS'(1);
            end
        end
    end

    assign set_vec = (pins_f_d & ~pins_f_q & rise_en_q) | (~pins_f_d & pins_f_q & fall_en_q);
    assign flags_d = (flags_q & ~clr_vec) | set_vec;

    assign req   = mem_valid && !ready_q;
    assign is_rd = (mem_wstrb == 4'h0);
    assign is_wr = (mem_wstrb == 4'hF);

    always_comb begin
        rdata_d   = '0;
        error_d   = 1'b0;
        thresh_d  = thresh_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        clr_vec   = '0;
        if (req) begin
            if (!is_rd && !is_wr) begin
                error_d = 1'b1;
            end else begin
                case (mem_addr)
                    ADDR_ID:     if (is_rd) rdata_d = ID_VALUE;        else error_d = 1'b1;
                    ADDR_CHAN:   if (is_rd) rdata_d = 32'(CHANNELS);   else error_d = 1'b1;
                    ADDR_PINS:   if (is_rd) rdata_d = 32'(pins_f_q);   else error_d = 1'b1;
                    ADDR_THRESH: if (is_rd) rdata_d = 32'(thresh_q);   else thresh_d  = mem_wdata[FILTER_BITS-1:0];
                    ADDR_RISE:   if (is_rd) rdata_d = 32'(rise_en_q);  else rise_en_d = mem_wdata[CHANNELS-1:0];
                    ADDR_FALL:   if (is_rd) rdata_d = 32'(fall_en_q);  else fall_en_d = mem_wdata[CHANNELS-1:0];
                    ADDR_FLAGS:  if (is_rd) rdata_d = 32'(flags_q);    else clr_vec   = mem_wdata[CHANNELS-1:0];
                    ADDR_MASK:   if (is_rd) rdata_d = 32'(mask_q);     else mask_d    = mem_wdata[CHANNELS-1:0];
`ifdef GPIO_FILTER_TIMESTAMP_EN
                    ADDR_TS_CAP:  if (is_rd) rdata_d = cap_q; else error_d = 1'b1;
                    ADDR_TS_LIVE: if (is_rd) rdata_d = ts_q;  else error_d = 1'b1;
`endif
                    default:     error_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pins_f_q  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            thresh_q  <= FILTER_BITS'(THRESH_RESET);
            rise_en_q <= '0;
            fall_en_q <= '0;
            flags_q   <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            sync1_q   <= pins_raw;
            sync2_q   <= sync1_q;
            pins_f_q  <= pins_f_d;
            for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
            thresh_q  <= thresh_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            flags_q   <= flags_d;
            mask_q    <= mask_d;
            irq_q     <= |(flags_q & mask_q);
            ready_q   <= req;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef GPIO_FILTER_TIMESTAMP_EN
    // Capture only when a flag bit goes 0->1; re-asserting an already set flag does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q  <= '0;
            cap_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (|(set_vec & ~flags_q)) cap_q <= ts_q;
        end
    end
`endif

    assign pins_f    = pins_f_q;
    assign irq       = irq_q;
    assign mem_ready = ready_q;
    assign mem_error = error_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Scoreboard bench for gpio_input_filter: a cycle-level behavioural model predicts pins_f, irq and
// bus responses; a negedge monitor compares them against the DUT.
module tb_gpio_input_filter;

    localparam int CH = 4;
    localparam int FB = 16;
    localparam int TR = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic [3:0]    mem_wstrb = '0;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic          mem_error;
    logic [CH-1:0] pins_raw = '0;
    logic [CH-1:0] pins_f;
    logic          irq;

    always #5 clk = ~clk;

    gpio_input_filter #(
        .CHANNELS    (CH),
        .FILTER_BITS (FB),
        .THRESH_RESET(TR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_error(mem_error),
        .pins_raw (pins_raw),
        .pins_f   (pins_f),
        .irq      (irq)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;
    resp_t exp_q[$];

    // Reference model state
    logic [CH-1:0] m_sy1, m_sy2, m_pf, m_rise, m_fall, m_flags, m_mask;
    int            m_run [CH];
    int            m_thr;
    logic          m_irq, m_rdy;
    logic [31:0]   m_ts, m_cap;

    function automatic void model_reset();
        m_sy1 = '0; m_sy2 = '0; m_pf = '0;
        m_rise = '0; m_fall = '0; m_flags = '0; m_mask = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
        m_thr = TR;
        m_irq = 1'b0; m_rdy = 1'b0;
        m_ts = '0; m_cap = '0;
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            exp_q.delete();
        end else begin
            logic [CH-1:0] clr, n_pf, rises, falls, n_rise, n_fall, n_mask, newly;
            int            n_thr;
            resp_t         r;
            logic          rd, wr;
            clr = '0; n_rise = m_rise; n_fall = m_fall; n_mask = m_mask; n_thr = m_thr;
            if (mem_valid && !m_rdy) begin
                r  = '0;
                rd = (mem_wstrb == 4'h0);
                wr = (mem_wstrb == 4'hF);
                if (!rd && !wr) r.err = 1'b1;
                else case (mem_addr)
                    32'h00: if (rd) r.data = 32'h4750_4946; else r.err = 1'b1;
                    32'h04: if (rd) r.data = CH;            else r.err = 1'b1;
                    32'h08: if (rd) r.data = 32'(m_pf);     else r.err = 1'b1;
                    32'h0C: if (rd) r.data = 32'(m_thr);    else n_thr  = int'(mem_wdata % 65536);
                    32'h10: if (rd) r.data = 32'(m_rise);   else n_rise = mem_wdata[CH-1:0];
                    32'h14: if (rd) r.data = 32'(m_fall);   else n_fall = mem_wdata[CH-1:0];
                    32'h18: if (rd) r.data = 32'(m_flags);  else clr    = mem_wdata[CH-1:0];
                    32'h1C: if (rd) r.data = 32'(m_mask);   else n_mask = mem_wdata[CH-1:0];
`ifdef GPIO_FILTER_TIMESTAMP_EN
                    32'h20: if (rd) r.data = m_cap; else r.err = 1'b1;
                    32'h24: if (rd) r.data = m_ts;  else r.err = 1'b1;
`endif
                    default: r.err = 1'b1;
                endcase
                exp_q.push_back(r);
                m_rdy = 1'b1;
            end else begin
                m_rdy = 1'b0;
            end
            // Filter: a channel flips once its synced input has disagreed for more than T cycles in a row
            n_pf = m_pf;
            for (int i = 0; i < CH; i++) begin
                if (m_sy2[i] != m_pf[i]) begin
                    if (m_run[i] >= m_thr) begin n_pf[i] = m_sy2[i]; m_run[i] = 0; end
                    else m_run[i] = m_run[i] + 1;
                end else begin
                    m_run[i] = 0;
                end
            end
            rises = n_pf & ~m_pf & m_rise;
            falls = ~n_pf & m_pf & m_fall;
            newly = (rises | falls) & ~m_flags;
            m_irq = |(m_flags & m_mask);
            if (newly != '0) m_cap = m_ts;
            m_ts    = m_ts + 1;
            m_flags = (m_flags & ~clr) | rises | falls;
            m_rise = n_rise; m_fall = n_fall; m_mask = n_mask; m_thr = n_thr;
            m_sy2 = m_sy1; m_sy1 = pins_raw; m_pf = n_pf;
        end
    end

    // Monitor: per-cycle output checks plus scoreboard pop on every DUT response.
    int stale = 0;
    always @(negedge clk) begin
        resp_t r;
        check("pins_f", 32'(pins_f), 32'(m_pf));
        check("irq", 32'(irq), 32'(m_irq));
        check("mem_ready", 32'(mem_ready), 32'(m_rdy));
        if (mem_ready === 1'b1) begin
            stale = 0;
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_response: got ready=1 expected no response");
            end else begin
                r = exp_q.pop_front();
                check("rdata", mem_rdata, r.data);
                check("error", 32'(mem_error), 32'(r.err));
            end
        end else if (exp_q.size() != 0) begin
            stale++;
            if (stale > 3) begin
                vectors++; miscompares++;
                $display("FAIL missing_response: got no ready expected response within 3 cycles");
                r = exp_q.pop_front();
                stale = 0;
            end
        end
    end

    task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done;
        done = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) done = 1'b1;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL bus_timeout: got no ready expected ready within 8 cycles, addr %h", a);
        end
        mem_valid = 1'b0; mem_wstrb = '0;
    endtask

    logic [31:0] addr_tbl [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                   32'h18, 32'h1C, 32'h20, 32'h24, 32'h30, 32'h02};
    logic [3:0]  strb_tbl [7]  = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h3, 4'h8};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) bus_op(addr_tbl[i], 32'h0, 4'h0);

        // T=3: step on pin0 must appear exactly 6 clocks later
        bus_op(32'h0C, 32'd3, 4'hF);
        @(negedge clk); pins_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_step_early", 32'(pins_f[0]), 32'd0);
        @(negedge clk);
        check("t3_step_on_time", 32'(pins_f[0]), 32'd1);

        // 3-clock pulse is filtered out
        @(negedge clk); pins_raw[1] = 1'b1;
        repeat (3) @(negedge clk); pins_raw[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("t3_pulse_rejected", 32'(pins_f[1]), 32'd0);

        // T=0: toggle every 4 clocks
        bus_op(32'h0C, 32'd0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); pins_raw[1] = ~pins_raw[1];
            repeat (3) @(negedge clk);
        end

        // Rise flag, irq, W1C
        bus_op(32'h10, 32'h1, 4'hF);
        bus_op(32'h1C, 32'h1, 4'hF);
        @(negedge clk); pins_raw[0] = 1'b0;
        repeat (5) @(negedge clk); pins_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        bus_op(32'h18, 32'h0, 4'h0);
        bus_op(32'h18, 32'h1, 4'hF);
        repeat (3) @(negedge clk);

        // W1C accepted on the same edge a new rise sets flag 0
        pins_raw[0] = 1'b0;
        repeat (5) @(negedge clk);
        pins_raw[0] = 1'b1;
        @(negedge clk);
        bus_op(32'h18, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        check("w1c_vs_set_irq", 32'(irq), 32'd1);
        bus_op(32'h18, 32'h0, 4'h0);

        // Error cases
        bus_op(32'h30, 32'h0, 4'h0);
        bus_op(32'h10, 32'hF, 4'h3);
        bus_op(32'h10, 32'h0, 4'h0);
        bus_op(32'h00, 32'h5, 4'hF);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                @(negedge clk); pins_raw = CH'($urandom);
            end else if (op < 6) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end else begin
                logic [31:0] a, d;
                a = addr_tbl[$urandom_range(0, 11)];
                d = $urandom;
                if (a == 32'h0C) d = {d[31:16], 16'($urandom_range(0, 4))};
                bus_op(a, d, strb_tbl[$urandom_range(0, 6)]);
            end
        end

        // Reset while counting with flags set
        bus_op(32'h0C, 32'd10, 4'hF);
        bus_op(32'h10, 32'hF, 4'hF);
        bus_op(32'h14, 32'hF, 4'hF);
        bus_op(32'h1C, 32'hF, 4'hF);
        @(negedge clk); pins_raw = ~pins_f;
        repeat (16) @(negedge clk);
        pins_raw = ~pins_raw;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_pins_f", 32'(pins_f), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        bus_op(32'h0C, 32'h0, 4'h0);
        bus_op(32'h18, 32'h0, 4'h0);
        repeat (20) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1);
    end

endmodule
